// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath; 2-5 cycles per instruction (FETCH back to FETCH).
// No backpressure: advances every clock; pcen and ULAcontrol are combined with zero/funct outside the registers.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               ULAsrcA,
  output logic [1:0]         ULAsrcB,
  output logic [1:0]         pcsrc,
  output logic [2:0]         ULAcontrol,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX    = 4'd11
  } state_t;

  typedef enum logic [1:0] {UOP_NONE, UOP_ADD, UOP_SUB, UOP_FUNCT} ulaop_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    ulaop_t     ulaop;
  } ctrl_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  state_t state, nxt;
  ctrl_t  ctrl;

  // Control word for a state; registered together with the state so the outputs never glitch.
  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.memread = 1'b1; c.irwrite = 1'b1; c.srcb = 2'b01;
                     c.ulaop = UOP_ADD; c.pcwrite = 1'b1; end
      DECODE:  begin c.srcb = 2'b11; c.ulaop = UOP_ADD; end
      MEMADR:  begin c.srca = 1'b1; c.srcb = 2'b10; c.ulaop = UOP_ADD; end
      MEMRD:   begin c.iord = 1'b1; c.memread = 1'b1; end
      MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.srca = 1'b1; c.ulaop = UOP_FUNCT; end
      RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BEQEX:   begin c.srca = 1'b1; c.ulaop = UOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.srca = 1'b1; c.srcb = 2'b10; c.ulaop = UOP_ADD; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= decode_state(FETCH);
    end else begin
      state <= nxt;
      ctrl  <= decode_state(nxt);
    end
  end

  // funct is only consulted while executing an R-type; the IR is stable by then.
  always_comb begin
    ULAcontrol = 3'b000;
    case (ctrl.ulaop)
      UOP_ADD:   ULAcontrol = 3'b010;
      UOP_SUB:   ULAcontrol = 3'b110;
      UOP_FUNCT:
        case (funct)
          6'b100010: ULAcontrol = 3'b110;
          6'b100100: ULAcontrol = 3'b000;
          6'b100101: ULAcontrol = 3'b001;
          6'b101010: ULAcontrol = 3'b111;
          default:   ULAcontrol = 3'b010;
        endcase
      default:   ULAcontrol = 3'b000;
    endcase
  end

  assign pcen      = ctrl.pcwrite | (ctrl.branch & zero);
  assign iord      = ctrl.iord;
  assign memread   = ctrl.memread;
  assign memwrite  = ctrl.memwrite;
  assign irwrite   = ctrl.irwrite;
  assign memtoreg  = ctrl.memtoreg;
  assign regdst    = ctrl.regdst;
  assign regwrite  = ctrl.regwrite;
  assign ULAsrcA   = ctrl.srca;
  assign ULAsrcB   = ctrl.srcb;
  assign pcsrc     = ctrl.pcsrc;
  assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected state/control words queued at issue, compared at negedge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, ULAsrcA;
  logic [1:0] ULAsrcB, pcsrc;
  logic [2:0] ULAcontrol;
  logic [3:0] dbg_state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .ULAsrcA(ULAsrcA), .ULAsrcB(ULAsrcB), .pcsrc(pcsrc), .ULAcontrol(ULAcontrol),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] ulactl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs per state, written straight from the state table.
  function automatic exp_t model(input logic [3:0] s, input logic [5:0] f, input logic z);
    exp_t e;
    e = '0;
    e.st = s;
    case (s)
      4'd0:  begin e.pcen = 1; e.memread = 1; e.irwrite = 1; e.srcb = 2'b01; e.ulactl = 3'b010; end
      4'd1:  begin e.srcb = 2'b11; e.ulactl = 3'b010; end
      4'd2:  begin e.srca = 1; e.srcb = 2'b10; e.ulactl = 3'b010; end
      4'd3:  begin e.iord = 1; e.memread = 1; end
      4'd4:  begin e.regwrite = 1; e.memtoreg = 1; end
      4'd5:  begin e.iord = 1; e.memwrite = 1; end
      4'd6: begin
        e.srca = 1;
        case (f)
          6'b100000: e.ulactl = 3'b010;
          6'b100010: e.ulactl = 3'b110;
          6'b100100: e.ulactl = 3'b000;
          6'b100101: e.ulactl = 3'b001;
          6'b101010: e.ulactl = 3'b111;
          default:   e.ulactl = 3'b010;
        endcase
      end
      4'd7:  begin e.regwrite = 1; e.regdst = 1; end
      4'd8:  begin e.pcen = z; e.srca = 1; e.pcsrc = 2'b01; e.ulactl = 3'b110; end
      4'd9:  begin e.srca = 1; e.srcb = 2'b10; e.ulactl = 3'b010; end
      4'd10: e.regwrite = 1;
      4'd11: begin e.pcen = 1; e.pcsrc = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  exp_t mon_e, mon_a;
  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a.st       = dbg_state;
      mon_a.pcen     = pcen;
      mon_a.iord     = iord;
      mon_a.memread  = memread;
      mon_a.memwrite = memwrite;
      mon_a.irwrite  = irwrite;
      mon_a.memtoreg = memtoreg;
      mon_a.regdst   = regdst;
      mon_a.regwrite = regwrite;
      mon_a.srca     = ULAsrcA;
      mon_a.srcb     = ULAsrcB;
      mon_a.pcsrc    = pcsrc;
      mon_a.ulactl   = ULAcontrol;
      expect_eq("state", 32'(mon_a.st), 32'(mon_e.st));
      expect_eq($sformatf("ctl@s%0d_op%b", mon_e.st, op), 32'(mon_a), 32'(mon_e));
      expect_eq("mem_rw_excl", 32'(memread & memwrite), 32'd0);
      expect_eq("rw_ir_excl", 32'(regwrite & irwrite), 32'd0);
    end
  end

  // Called at posedge+1 with the FSM in FETCH; returns at posedge+1 when it is back in FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    logic [3:0] seq[$];
    op = o; funct = f; zero = z;
    seq.push_back(4'd0);
    seq.push_back(4'd1);
    case (o)
      6'b100011: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
      6'b101011: begin seq.push_back(4'd2); seq.push_back(4'd5); end
      6'b000000: begin seq.push_back(4'd6); seq.push_back(4'd7); end
      6'b000100: seq.push_back(4'd8);
      6'b001000: begin seq.push_back(4'd9); seq.push_back(4'd10); end
      6'b000010: seq.push_back(4'd11);
      default: ;
    endcase
    foreach (seq[i]) q.push_back(model(seq[i], f, z));
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_state", 32'(dbg_state), 32'd0);
    expect_eq("rst_memread", 32'(memread), 32'd1);
    expect_eq("rst_irwrite", 32'(irwrite), 32'd1);
    expect_eq("rst_pcen", 32'(pcen), 32'd1);
    expect_eq("rst_regwrite", 32'(regwrite), 32'd0);
    expect_eq("rst_ulactl", 32'(ULAcontrol), 32'd2);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(6'b100011, 6'b000000, 1'b0);  // lw
    run_instr(6'b101011, 6'b000000, 1'b0);  // sw
    run_instr(6'b000000, 6'b101010, 1'b0);  // slt
    run_instr(6'b000000, 6'b100100, 1'b0);  // and
    run_instr(6'b000000, 6'b100000, 1'b0);  // add
    run_instr(6'b000000, 6'b100010, 1'b1);  // sub
    run_instr(6'b000000, 6'b100101, 1'b0);  // or
    run_instr(6'b000000, 6'b000111, 1'b0);  // unknown funct
    run_instr(6'b000100, 6'b000000, 1'b1);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0);  // beq not taken
    run_instr(6'b001000, 6'b101010, 1'b1);  // addi
    run_instr(6'b000010, 6'b000000, 1'b0);  // j
    run_instr(6'b111111, 6'b000000, 1'b0);  // unknown op

    // lw interrupted by reset while in MEMRD
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    for (int s = 0; s < 4; s++) q.push_back(model(4'(s), 6'd0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    expect_eq("async_rst_state", 32'(dbg_state), 32'd0);
    expect_eq("async_rst_memread", 32'(memread), 32'd1);
    expect_eq("async_rst_iord", 32'(iord), 32'd0);
    expect_eq("async_rst_regwrite", 32'(regwrite), 32'd0);
    expect_eq("async_rst_q", 32'(q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    expect_eq("held_rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(6'b000010, 6'b000000, 1'b0);  // j after reset
    run_instr(6'b001000, 6'b000000, 1'b0);  // addi after reset

    @(negedge clk);
    expect_eq("q_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
